// File: rtl/tb_doutb_skew_map_if.sv
// Bus between the TB port-B read side and the skewed B / B_cache operand lanes.
// Every signal is valid-only: a beat is taken on any cycle with TB_doutb_valid=1; there is no ready.
interface tb_doutb_skew_map_if #(
  parameter int Y      = 4,
  parameter int L      = 4,
  parameter int RSA_DW = 16,
  parameter int SEG    = 2
);
  localparam int NSEG = L / SEG;
  localparam int SEGW = (NSEG > 1) ? $clog2(NSEG) : 1;

  logic [2:0]          TB_doutb_sel;
  logic [SEGW-1:0]     seg_idx;
  logic                TB_doutb_valid;
  logic [L*RSA_DW-1:0] TB_doutb;
  logic [Y*RSA_DW-1:0] B_TB_doutb;
  logic [Y-1:0]        B_valid;
  logic [Y*RSA_DW-1:0] B_cache_TB_doutb;
  logic [Y-1:0]        B_cache_valid;
  logic                busy;

  modport master (
    output TB_doutb_sel, seg_idx, TB_doutb_valid, TB_doutb,
    input  B_TB_doutb, B_valid, B_cache_TB_doutb, B_cache_valid, busy
  );

  modport slave (
    input  TB_doutb_sel, seg_idx, TB_doutb_valid, TB_doutb,
    output B_TB_doutb, B_valid, B_cache_TB_doutb, B_cache_valid, busy
  );
endinterface

// File: rtl/tb_doutb_skew_map.sv
// Maps one TB BRAM read word onto the RSA B or B_cache lanes (POS / NEG / NEW modes)
// and skews lane i by i cycles so it enters the systolic array aligned.
module tb_doutb_skew_map #(
  parameter int X       = 4,
  parameter int Y       = 4,
  parameter int L       = 4,
  parameter int RSA_DW  = 16,
  parameter int SEG     = 2,
  parameter bit SKEW_EN = 1'b1
) (
  input  logic                clk,
  input  logic                sys_rst,
  tb_doutb_skew_map_if.slave  bus
);
  logic [1:0] mode;
  logic       dest;
  logic       accept;
  logic [Y-1:0] lane_busy;
  logic [RSA_DW-1:0] in_lane [L];

  assign mode   = bus.TB_doutb_sel[1:0];
  assign dest   = bus.TB_doutb_sel[2];
  assign accept = bus.TB_doutb_valid && (mode != 2'b00);

  for (genvar k = 0; k < L; k++) begin : g_in
    assign in_lane[k] = bus.TB_doutb[k*RSA_DW +: RSA_DW];
  end

  for (genvar i = 0; i < Y; i++) begin : g_lane
    // Depth of this lane's chain beyond the map register.
    localparam int D = SKEW_EN ? i : 0;

    int                src;
    logic              src_ok;
    logic              map_v;
    logic [RSA_DW-1:0] map_d;

    logic [RSA_DW-1:0] pd [D+1];
    logic              pv [D+1];
    logic              pt [D+1];
    logic              lb;

    always_comb begin
      src    = 0;
      src_ok = 1'b0;
      case (mode)
        2'b01: begin
          src    = i;
          src_ok = (i < L);
        end
        2'b10: begin
          src    = X - 1 - i;
          src_ok = (X - 1 - i >= 0) && (X - 1 - i < L);
        end
        2'b11: begin
          src    = int'(bus.seg_idx) * SEG + i;
          src_ok = (i < SEG) && (src < L);
        end
        default: ;
      endcase
      map_v = accept && src_ok;
      map_d = '0;
      for (int k = 0; k < L; k++) begin
        if (map_v && (src == k)) map_d = in_lane[k];
      end
    end

    // Data, lane valid and destination move as one tuple so back-to-back beats never mix.
    always_ff @(posedge clk or negedge sys_rst) begin
      if (!sys_rst) begin
        for (int d = 0; d <= D; d++) begin
          pd[d] <= '0;
          pv[d] <= 1'b0;
          pt[d] <= 1'b0;
        end
      end else begin
        pd[0] <= map_d;
        pv[0] <= map_v;
        pt[0] <= accept & dest;
        for (int d = 1; d <= D; d++) begin
          pd[d] <= pd[d-1];
          pv[d] <= pv[d-1];
          pt[d] <= pt[d-1];
        end
      end
    end

    always_comb begin
      lb = 1'b0;
      for (int d = 0; d <= D; d++) lb = lb | pv[d];
    end

    assign lane_busy[i] = lb;

    assign bus.B_TB_doutb[i*RSA_DW +: RSA_DW]       = pt[D] ? '0 : pd[D];
    assign bus.B_valid[i]                           = pv[D] & ~pt[D];
    assign bus.B_cache_TB_doutb[i*RSA_DW +: RSA_DW] = pt[D] ? pd[D] : '0;
    assign bus.B_cache_valid[i]                     = pv[D] & pt[D];
  end

  assign bus.busy = |lane_busy;
endmodule

// File: tb/tb_tb_doutb_skew_map.sv
// Directed bench for tb_doutb_skew_map: a skewed instance and an unskewed instance,
// one task per scenario, each sampling all outputs at the falling edge.
module tb_tb_doutb_skew_map;
  logic clk;
  logic sys_rst;
  int   n_checks;
  int   n_pass;

  localparam logic [63:0] WORD = 64'h0004_0003_0002_0001;

  tb_doutb_skew_map_if #(.Y(4), .L(4), .RSA_DW(16), .SEG(2)) if_a ();
  tb_doutb_skew_map_if #(.Y(4), .L(4), .RSA_DW(16), .SEG(2)) if_b ();

  tb_doutb_skew_map #(.X(4), .Y(4), .L(4), .RSA_DW(16), .SEG(2), .SKEW_EN(1'b1)) dut_a (
    .clk     (clk),
    .sys_rst (sys_rst),
    .bus     (if_a.slave)
  );

  tb_doutb_skew_map #(.X(4), .Y(4), .L(4), .RSA_DW(16), .SEG(2), .SKEW_EN(1'b0)) dut_b (
    .clk     (clk),
    .sys_rst (sys_rst),
    .bus     (if_b.slave)
  );

  // Observed tuple: {B, B_valid, B_cache, B_cache_valid, busy}
  logic [136:0] obs_a;
  logic [136:0] obs_b;
  assign obs_a = {if_a.B_TB_doutb, if_a.B_valid, if_a.B_cache_TB_doutb, if_a.B_cache_valid, if_a.busy};
  assign obs_b = {if_b.B_TB_doutb, if_b.B_valid, if_b.B_cache_TB_doutb, if_b.B_cache_valid, if_b.busy};

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic drive_a(input logic [2:0] sel, input logic seg, input logic vld);
    if_a.TB_doutb_sel   = sel;
    if_a.seg_idx        = seg;
    if_a.TB_doutb_valid = vld;
    if_a.TB_doutb       = WORD;
  endtask

  task automatic drive_b(input logic [2:0] sel, input logic seg, input logic vld);
    if_b.TB_doutb_sel   = sel;
    if_b.seg_idx        = seg;
    if_b.TB_doutb_valid = vld;
    if_b.TB_doutb       = WORD;
  endtask

  task automatic test_reset();
    sys_rst = 1'b0;
    drive_a(3'b000, 1'b0, 1'b0);
    drive_b(3'b000, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    n_checks++;
    if (obs_a !== 137'h0) $display("FAIL reset_held_a got %h exp 0", obs_a); else n_pass++;
    n_checks++;
    if (obs_b !== 137'h0) $display("FAIL reset_held_b got %h exp 0", obs_b); else n_pass++;
    sys_rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs_a !== 137'h0) $display("FAIL reset_release_a got %h exp 0", obs_a); else n_pass++;
  endtask

  task automatic test_pos();
    logic [63:0]  eb [1:5] = '{64'h1, 64'h2_0000, 64'h3_0000_0000, 64'h4_0000_0000_0000, 64'h0};
    logic [3:0]   ev [1:5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    logic [136:0] exp_v;
    drive_a(3'b001, 1'b0, 1'b1);
    @(negedge clk);
    drive_a(3'b000, 1'b0, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      exp_v = {eb[c], ev[c], 64'h0, 4'h0, (c <= 4)};
      n_checks++;
      if (obs_a !== exp_v) $display("FAIL pos_b c%0d got %h exp %h", c, obs_a, exp_v); else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_neg();
    logic [63:0]  eb [1:5] = '{64'h4, 64'h3_0000, 64'h2_0000_0000, 64'h1_0000_0000_0000, 64'h0};
    logic [3:0]   ev [1:5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    logic [136:0] exp_v;
    drive_a(3'b110, 1'b0, 1'b1);
    @(negedge clk);
    drive_a(3'b000, 1'b0, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      exp_v = {64'h0, 4'h0, eb[c], ev[c], (c <= 4)};
      n_checks++;
      if (obs_a !== exp_v) $display("FAIL neg_bc c%0d got %h exp %h", c, obs_a, exp_v); else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_new();
    logic [63:0]  e1 [1:3] = '{64'h3, 64'h4_0000, 64'h0};
    logic [63:0]  e0 [1:3] = '{64'h1, 64'h2_0000, 64'h0};
    logic [3:0]   ev [1:3] = '{4'b0001, 4'b0010, 4'b0000};
    logic [136:0] exp_v;
    drive_a(3'b011, 1'b1, 1'b1);
    @(negedge clk);
    drive_a(3'b000, 1'b0, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      exp_v = {e1[c], ev[c], 64'h0, 4'h0, (c <= 2)};
      n_checks++;
      if (obs_a !== exp_v) $display("FAIL new_seg1 c%0d got %h exp %h", c, obs_a, exp_v); else n_pass++;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    drive_a(3'b011, 1'b0, 1'b1);
    @(negedge clk);
    drive_a(3'b000, 1'b0, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      exp_v = {e0[c], ev[c], 64'h0, 4'h0, (c <= 2)};
      n_checks++;
      if (obs_a !== exp_v) $display("FAIL new_seg0 c%0d got %h exp %h", c, obs_a, exp_v); else n_pass++;
      @(negedge clk);
    end
  endtask

  // Scoreboard: expected tuples queued up front, popped once per cycle.
  task automatic test_back_to_back();
    logic [136:0] exp_q[$];
    logic [136:0] exp_v;
    exp_q.push_back({64'h1,                  4'b0001, 64'h0,                  4'b0000, 1'b1});
    exp_q.push_back({64'h2_0000,             4'b0010, 64'h4,                  4'b0001, 1'b1});
    exp_q.push_back({64'h3_0000_0000,        4'b0100, 64'h3_0000,             4'b0010, 1'b1});
    exp_q.push_back({64'h4_0000_0000_0000,   4'b1000, 64'h2_0000_0000,        4'b0100, 1'b1});
    exp_q.push_back({64'h0,                  4'b0000, 64'h1_0000_0000_0000,   4'b1000, 1'b1});
    exp_q.push_back({64'h0,                  4'b0000, 64'h0,                  4'b0000, 1'b0});
    drive_a(3'b001, 1'b0, 1'b1);
    @(negedge clk);
    drive_a(3'b110, 1'b0, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs_a !== exp_v) $display("FAIL b2b c%0d got %h exp %h", c, obs_a, exp_v); else n_pass++;
      @(negedge clk);
      drive_a(3'b000, 1'b0, 1'b0);
    end
  endtask

  task automatic test_mid_reset();
    logic [136:0] exp_v;
    drive_a(3'b001, 1'b0, 1'b1);
    @(negedge clk);
    drive_a(3'b000, 1'b0, 1'b0);
    exp_v = {64'h1, 4'b0001, 64'h0, 4'b0000, 1'b1};
    n_checks++;
    if (obs_a !== exp_v) $display("FAIL midrst_c1 got %h exp %h", obs_a, exp_v); else n_pass++;
    @(posedge clk);
    #1 sys_rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs_a !== 137'h0) $display("FAIL midrst_c2 got %h exp 0", obs_a); else n_pass++;
    @(posedge clk);
    #1 sys_rst = 1'b1;
    for (int c = 3; c <= 7; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs_a !== 137'h0) $display("FAIL midrst_c%0d got %h exp 0", c, obs_a); else n_pass++;
    end
  endtask

  task automatic test_no_skew();
    logic [136:0] exp_v;
    drive_b(3'b001, 1'b0, 1'b1);
    @(negedge clk);
    drive_b(3'b000, 1'b0, 1'b0);
    exp_v = {WORD, 4'b1111, 64'h0, 4'b0000, 1'b1};
    n_checks++;
    if (obs_b !== exp_v) $display("FAIL noskew_pos_c1 got %h exp %h", obs_b, exp_v); else n_pass++;
    @(negedge clk);
    n_checks++;
    if (obs_b !== 137'h0) $display("FAIL noskew_pos_c2 got %h exp 0", obs_b); else n_pass++;
    drive_b(3'b110, 1'b0, 1'b1);
    @(negedge clk);
    drive_b(3'b000, 1'b0, 1'b0);
    exp_v = {64'h0, 4'b0000, 64'h0001_0002_0003_0004, 4'b1111, 1'b1};
    n_checks++;
    if (obs_b !== exp_v) $display("FAIL noskew_neg_c1 got %h exp %h", obs_b, exp_v); else n_pass++;
    drive_b(3'b100, 1'b0, 1'b1);
    @(negedge clk);
    n_checks++;
    if (obs_b !== 137'h0) $display("FAIL noskew_idle got %h exp 0", obs_b); else n_pass++;
    drive_b(3'b001, 1'b0, 1'b0);
    @(negedge clk);
    drive_b(3'b000, 1'b0, 1'b0);
    n_checks++;
    if (obs_b !== 137'h0) $display("FAIL noskew_novalid got %h exp 0", obs_b); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_pos();
    test_neg();
    test_new();
    repeat (2) @(negedge clk);
    test_back_to_back();
    test_mid_reset();
    test_no_skew();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/tb_doutb_skew_map.md
Name: tb_doutb_skew_map

Overview:
- Parametrised successor to the TB port-B read mapper. Routes one TB BRAM read word to either the B or the B_cache operand bus of the RSA.
- Supports forward, reversed and segment-select lane mapping, with per-beat valid and destination tags.
- Adds a per-lane systolic skew stage so lane i enters the array i cycles after lane 0. This removes the external skew registers on the B path.

Parameters:
- X, 4, RSA row count; width of the NEG mirror.
- Y, 4, RSA column count; number of output lanes.
- L, 4, TB BRAM lanes per word.
- RSA_DW, 16, lane data width.
- SEG, 2, lanes per segment in NEW mode.
- SKEW_EN, 1, 1 = lane i gets i extra delay cycles; 0 = all lanes see latency 1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- sys_rst  in  1  asynchronous, active-low reset.
- TB_doutb_sel  in  3  [2] destination (0 = B, 1 = B_cache); [1:0] mode (00 IDLE, 01 POS, 10 NEG, 11 NEW).
- seg_idx  in  max(1,$clog2(L/SEG))  segment select for NEW mode.
- TB_doutb_valid  in  1  TB_doutb beat valid this cycle.
- TB_doutb  in  L*RSA_DW  BRAM read word; lane k = bits [k*RSA_DW +: RSA_DW].
- B_TB_doutb  out  Y*RSA_DW  skewed B operand lanes.
- B_valid  out  Y  per-lane valid for B_TB_doutb.
- B_cache_TB_doutb  out  Y*RSA_DW  skewed B_cache operand lanes.
- B_cache_valid  out  Y  per-lane valid for B_cache_TB_doutb.
- busy  out  1  any beat still in the pipeline.

Behaviour:
- Reset (sys_rst=0, asynchronous): all pipeline data, valid and destination registers clear to 0. Every output reads 0 while reset is held and on the first cycle after release.
- Stage 1 (map) is registered and captures the mode, destination and data for the beat.
- A beat is accepted when TB_doutb_valid=1 and mode is not IDLE. Otherwise stage 1 loads zero data, all lane-valids 0, and destination 0.
- POS: out lane i = in lane i for i<min(Y,L); lanes i>=L are 0 with valid 0.
- NEG: out lane i = in lane (X-1-i) when 0<=X-1-i<L; otherwise 0 with valid 0.
- NEW: out lane j = in lane (seg_idx*SEG + j) for j<SEG and index<L. Lanes j>=SEG are 0 with valid 0. If seg_idx*SEG>=L, all lanes are 0 and valid 0.
- Generated lane valids: 1 for every lane carrying a sourced value, 0 otherwise.
- Stage 2 (skew), SKEW_EN=1: lane i passes through i additional registers. The data, lane valid and destination bit travel together in each lane's chain.
- Stage 2, SKEW_EN=0: stage-1 registers drive the outputs directly.
- Latency: lane i output appears 1+i cycles after the input beat (SKEW_EN=1), or 1 cycle for all lanes (SKEW_EN=0).
- Output demux is per lane, using that lane's carried destination bit:
  - dest 0: B lane = data, B_valid = lane valid; B_cache lane = 0, B_cache_valid = 0.
  - dest 1: the mirror of dest 0.
- Unselected destination lanes are always 0.
- Throughput is one beat per cycle, with no backpressure. Back-to-back beats with different modes or destinations never mix, because each lane carries its own tags.
- busy = OR of all valid bits in stage 1 and all skew registers. It deasserts on the cycle after the last lane of the last beat leaves.
- Mid-operation reset: in-flight beats are discarded immediately; nothing emerges after release.

Test Plan:
Defaults X=Y=L=4, DW=16, SEG=2. TB_doutb lanes 0..3 = 0x0001, 0x0002, 0x0003, 0x0004. Beat valid at cycle 0.
- POS, dest B -> B lane0=0x0001 @1, lane1=0x0002 @2, lane2=0x0003 @3, lane3=0x0004 @4, each with its B_valid bit high for exactly that cycle. B_cache all 0; busy high cycles 1-4.
- NEG, dest B_cache -> B_cache lane0=0x0004 @1, lane1=0x0003 @2, lane2=0x0002 @3, lane3=0x0001 @4. B stays 0.
- NEW, seg_idx=1 -> lane0=0x0003 @1, lane1=0x0004 @2; lanes 2 and 3 = 0 with valid 0. Repeat with seg_idx=0 -> 0x0001, 0x0002.
- Back-to-back: POS/B at cycle 0, NEG/B_cache at cycle 1 -> B_cache lane0=0x0004 @2 while B lane1=0x0002 @2. No cross-contamination; busy stays high continuously until it drops after cycle 5.
- Beat at cycle 0, sys_rst pulled low at cycle 2 and released at cycle 3 -> all outputs 0 from cycle 2 onward, and busy=0.
- SKEW_EN=0, POS/B -> all four lanes valid together at cycle 1. An IDLE or valid=0 input produces all-zero outputs.
